// File: rtl/regfile_dump.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump
// Brief    : Halts the core, walks the register file debug port and streams
//            {index, value} beats over a valid/ready interface.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              halt_req,
    input  logic              halt_ack,
    output logic [IDX_W-1:0]  dbg_raddr,
    input  logic [DATA_W-1:0] dbg_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_HALT   = 3'd1;
    localparam logic [2:0] c_READ   = 3'd2;
    localparam logic [2:0] c_SEND   = 3'd3;
    localparam logic [2:0] c_FINISH = 3'd4;

    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(NUM_REGS - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_raddr;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic              w_ptr_is_last;

    assign w_ptr_is_last = (r_ptr == c_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:   if (start)     w_next_state = c_HALT;
            c_HALT:   if (halt_ack)  w_next_state = c_READ;
            c_READ:                  w_next_state = c_SEND;
            c_SEND:   if (out_ready) w_next_state = w_ptr_is_last ? c_FINISH : c_READ;
            c_FINISH:                w_next_state = c_IDLE;
            default:                 w_next_state = c_IDLE;
        endcase
    end

    // Beat fields are loaded only from READ, so they hold through any SEND stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr   <= '0;
            r_raddr <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_ptr <= '0;
                    end
                end
                c_HALT: begin
                    if (halt_ack) begin
                        r_raddr <= r_ptr;
                    end
                end
                c_READ: begin
                    r_data <= dbg_rdata;
                    r_idx  <= r_ptr;
                    r_last <= w_ptr_is_last;
                end
                c_SEND: begin
                    if (out_ready && !w_ptr_is_last) begin
                        r_ptr   <= r_ptr + 1'b1;
                        r_raddr <= r_ptr + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Control outputs decode straight from state so reset clears them asynchronously.
    always_comb begin
        busy      = (r_state != c_IDLE);
        halt_req  = (r_state == c_HALT) || (r_state == c_READ) || (r_state == c_SEND);
        out_valid = (r_state == c_SEND);
        done      = (r_state == c_FINISH);
    end

    assign dbg_raddr = r_raddr;
    assign out_idx   = r_idx;
    assign out_data  = r_data;
    assign out_last  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_dump
// Brief    : Scoreboard bench for regfile_dump: halt handshake, streaming,
//            backpressure, mid-dump reset and ignored restart.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_dump;

    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;
    localparam int IDX_W    = 5;

    typedef struct {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              halt_req;
    logic              halt_ack = 1'b1;
    logic [IDX_W-1:0]  dbg_raddr;
    logic [DATA_W-1:0] dbg_rdata;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [IDX_W-1:0]  out_idx;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] regs [NUM_REGS];
    beat_t             sb_q[$];
    int                checks = 0;
    int                errors = 0;

    assign dbg_rdata = regs[dbg_raddr];

    always #5 clk = ~clk;

    regfile_dump #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .halt_ack(halt_ack),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    function automatic logic [2*IDX_W+DATA_W+4:0] all_outs();
        return {halt_req, out_valid, out_last, busy, done, dbg_raddr, out_idx, out_data};
    endfunction

    task automatic load_basic();
        for (int i = 0; i < NUM_REGS; i++) regs[i] = '0;
        regs[1] = 32'd5;
        regs[2] = 32'd10;
        regs[3] = 32'd15;
    endtask

    task automatic load_random();
        regs[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) regs[i] = $urandom;
    endtask

    task automatic push_expected();
        for (int i = 0; i < NUM_REGS; i++) begin
            beat_t b;
            b.idx  = IDX_W'(i);
            b.data = regs[i];
            b.last = (i == NUM_REGS - 1);
            sb_q.push_back(b);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Observes at negedge, drives 1 time unit after posedge.
    task automatic run_dump(input int ready_pct, input int reset_at, input int restart_idx,
                            output int nbeats, output int ndone);
        beat_t             exp;
        bit                pend_done = 1'b0;
        bit                stalled = 1'b0;
        bit                arm_restart = 1'b0;
        bit                restarted = 1'b0;
        logic [IDX_W-1:0]  h_idx;
        logic [DATA_W-1:0] h_data;
        logic              h_last;
        int                cycles = 0;
        nbeats = 0;
        ndone  = 0;
        forever begin
            @(negedge clk);
            if (reset_at >= 0 && nbeats == reset_at) begin
                #2 rst = 1'b0;
                #1;
                checks++;
                if (all_outs() !== '0) begin
                    errors++;
                    $display("FAIL midreset_outs got %h want 0", all_outs());
                end
                return;
            end
            checks++;
            if (done !== pend_done) begin
                errors++;
                $display("FAIL done_pulse got %b want %b (beats %0d)", done, pend_done, nbeats);
            end
            if (pend_done) begin
                ndone++;
                checks++;
                if (halt_req !== 1'b0) begin
                    errors++;
                    $display("FAIL halt_drop got %b want 0", halt_req);
                end
            end
            pend_done = 1'b0;
            if (out_valid === 1'b1) begin
                if (stalled) begin
                    checks++;
                    if (out_idx !== h_idx || out_data !== h_data || out_last !== h_last) begin
                        errors++;
                        $display("FAIL stall_hold got %0d/%h/%b want %0d/%h/%b",
                                 out_idx, out_data, out_last, h_idx, h_data, h_last);
                    end
                end
                if (out_ready) begin
                    stalled = 1'b0;
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_beat got idx %0d want none", out_idx);
                    end else begin
                        exp = sb_q.pop_front();
                        if (out_idx !== exp.idx || out_data !== exp.data || out_last !== exp.last) begin
                            errors++;
                            $display("FAIL beat got %0d/%h/%b want %0d/%h/%b",
                                     out_idx, out_data, out_last, exp.idx, exp.data, exp.last);
                        end
                        pend_done = exp.last;
                    end
                    nbeats++;
                end else begin
                    stalled = 1'b1;
                    h_idx  = out_idx;
                    h_data = out_data;
                    h_last = out_last;
                end
            end
            if (restart_idx >= 0 && !restarted && out_valid === 1'b0 && halt_req === 1'b1 &&
                dbg_raddr == IDX_W'(restart_idx)) begin
                arm_restart = 1'b1;
                restarted   = 1'b1;
            end
            if (ndone > 0 && sb_q.size() == 0) break;
            cycles++;
            if (cycles > 2000) begin
                errors++;
                $display("FAIL timeout got %0d beats want %0d", nbeats, NUM_REGS);
                break;
            end
            @(posedge clk); #1;
            start     = arm_restart;
            arm_restart = 1'b0;
            out_ready = ($urandom_range(99) < ready_pct);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL post_idle got busy %b done %b want 0 0", busy, done);
        end
        @(posedge clk); #1 out_ready = 1'b1;
    endtask

    task automatic check_totals(input string name, input int nbeats, input int ndone);
        checks++;
        if (nbeats != NUM_REGS || ndone != 1 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_totals got beats %0d done %0d left %0d want %0d 1 0",
                     name, nbeats, ndone, sb_q.size(), NUM_REGS);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_outs got %h want 0", all_outs());
        end
        rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (all_outs() !== '0) begin
                errors++;
                $display("FAIL idle_outs got %h want 0", all_outs());
            end
        end
    endtask

    task automatic test_basic_dump();
        int nb, nd;
        load_basic();
        halt_ack  = 1'b1;
        out_ready = 1'b1;
        push_expected();
        pulse_start();
        run_dump(100, -1, -1, nb, nd);
        check_totals("basic", nb, nd);
    endtask

    task automatic test_halt_delay();
        int nb, nd;
        logic [IDX_W-1:0] saved;
        load_basic();
        halt_ack = 1'b0;
        saved = dbg_raddr;
        push_expected();
        pulse_start();
        repeat (7) begin
            @(negedge clk);
            checks++;
            if (halt_req !== 1'b1 || out_valid !== 1'b0 || dbg_raddr !== saved || busy !== 1'b1) begin
                errors++;
                $display("FAIL halt_wait got req %b valid %b raddr %0d busy %b want 1 0 %0d 1",
                         halt_req, out_valid, dbg_raddr, busy, saved);
            end
        end
        @(posedge clk); #1 halt_ack = 1'b1;
        run_dump(100, -1, -1, nb, nd);
        check_totals("halt_delay", nb, nd);
    endtask

    task automatic test_backpressure();
        int nb, nd;
        load_random();
        push_expected();
        pulse_start();
        run_dump(70, -1, -1, nb, nd);
        check_totals("backpressure", nb, nd);
    endtask

    task automatic test_mid_reset();
        int nb, nd;
        load_random();
        push_expected();
        pulse_start();
        run_dump(100, 12, -1, nb, nd);
        checks++;
        if (nd != 0 || nb != 12) begin
            errors++;
            $display("FAIL midreset_progress got beats %0d done %0d want 12 0", nb, nd);
        end
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        push_expected();
        pulse_start();
        run_dump(100, -1, -1, nb, nd);
        check_totals("after_reset", nb, nd);
    endtask

    task automatic test_restart_ignored();
        int nb, nd;
        load_basic();
        push_expected();
        pulse_start();
        run_dump(100, -1, 4, nb, nd);
        check_totals("restart", nb, nd);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL restart_relaunch got busy %b want 0", busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_dump();
        test_halt_delay();
        test_backpressure();
        test_mid_reset();
        test_restart_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
